// File: rtl/keypad_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KP_W  = 4;
  localparam int unsigned DEB_W = 8;

  localparam logic [KP_W-1:0] ROW_IDLE  = 4'b1111;
  localparam logic [KP_W-1:0] ROW_FIRST = 4'b1110;

  localparam int unsigned SCAN_DIV_DEF     = 50000;
  localparam int unsigned DEBOUNCE_CNT_DEF = 8;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } kp_state_e;

  // Index of the lowest 0 bit in an active-low 4-bit line group.
  function automatic logic [1:0] zero_idx(input logic [KP_W-1:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = KP_W - 1; i >= 0; i--) begin
      if (!v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // True when exactly one line is pulled low.
  function automatic logic one_zero(input logic [KP_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < KP_W; i++) begin
      if (!v[i]) n++;
    end
    return n == 1;
  endfunction

endpackage

// File: rtl/scan_tick.sv
// Scan-rate prescaler: one-cycle tick every SCAN_DIV clocks.
module scan_tick
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEF
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] LAST     = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] PRE_LAST = CW'(SCAN_DIV - 2);

  logic [CW-1:0] r_count;
  logic          r_tick;

  // tick is registered one count early so it is high exactly while count == LAST
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_count <= (r_count == LAST) ? '0 : r_count + CW'(1);
      r_tick  <= (r_count == PRE_LAST);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: row drive, column sync, debounce FSM and key encoder.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = SCAN_DIV_DEF,
  parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [KP_W-1:0] keyCol,
  output logic [KP_W-1:0] keyRow,
  output logic [KP_W-1:0] key_code,
  output logic            key_valid,
  output logic            key_held
);

  localparam logic [DEB_W-1:0] DEB_TGT = DEB_W'(DEBOUNCE_CNT);
  localparam bit               DEB_ONE = (DEBOUNCE_CNT <= 1);

  logic              w_tick;
  logic [KP_W-1:0]   r_sync1, r_sync2;
  kp_state_e         r_state, w_state_nxt;
  logic [KP_W-1:0]   r_row, w_row_nxt, w_row_rot;
  logic [KP_W-1:0]   r_col_latch, w_latch_nxt;
  logic [DEB_W-1:0]  r_deb_cnt, w_deb_nxt, w_deb_inc;
  logic [KP_W-1:0]   r_key_code, w_code_nxt;
  logic              r_key_valid, w_valid_nxt;
  logic              r_key_held, w_held_nxt;

  scan_tick #(.SCAN_DIV(SCAN_DIV)) u_scan_tick (
    .clock (clock),
    .reset (reset),
    .tick  (w_tick)
  );

  // Two-flop column synchronizer; idle lines read high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= ROW_IDLE;
      r_sync2 <= ROW_IDLE;
    end else begin
      r_sync1 <= keyCol;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_SCAN;
      r_row       <= ROW_FIRST;
      r_col_latch <= ROW_IDLE;
      r_deb_cnt   <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_row       <= w_row_nxt;
      r_col_latch <= w_latch_nxt;
      r_deb_cnt   <= w_deb_nxt;
      r_key_code  <= w_code_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_held  <= w_held_nxt;
    end
  end

  // Next-state logic; every transition is gated by the scan tick.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row;
    w_latch_nxt = r_col_latch;
    w_deb_nxt   = r_deb_cnt;
    w_code_nxt  = r_key_code;
    w_valid_nxt = 1'b0;
    w_row_rot   = {r_row[KP_W-2:0], r_row[KP_W-1]};
    w_deb_inc   = (r_deb_cnt == '1) ? r_deb_cnt : r_deb_cnt + DEB_W'(1);

    if (w_tick) begin
      unique case (r_state)
        ST_SCAN: begin
          if (one_zero(r_sync2)) begin
            w_latch_nxt = r_sync2;
            w_deb_nxt   = DEB_W'(1);
            if (DEB_ONE) begin
              w_state_nxt = ST_PRESSED;
              w_code_nxt  = {zero_idx(r_row), zero_idx(r_sync2)};
              w_valid_nxt = 1'b1;
            end else begin
              w_state_nxt = ST_DEBOUNCE;
            end
          end else begin
            w_row_nxt = w_row_rot;
          end
        end
        ST_DEBOUNCE: begin
          if (r_sync2 == r_col_latch) begin
            w_deb_nxt = w_deb_inc;
            if (w_deb_inc >= DEB_TGT) begin
              w_state_nxt = ST_PRESSED;
              w_code_nxt  = {zero_idx(r_row), zero_idx(r_col_latch)};
              w_valid_nxt = 1'b1;
            end
          end else begin
            w_state_nxt = ST_SCAN;
            w_row_nxt   = w_row_rot;
            w_deb_nxt   = '0;
          end
        end
        ST_PRESSED: begin
          if (r_sync2 == ROW_IDLE) begin
            if (DEB_ONE) begin
              w_state_nxt = ST_SCAN;
              w_row_nxt   = w_row_rot;
              w_deb_nxt   = '0;
            end else begin
              w_state_nxt = ST_RELEASE;
              w_deb_nxt   = DEB_W'(1);
            end
          end
        end
        ST_RELEASE: begin
          if (r_sync2 == ROW_IDLE) begin
            w_deb_nxt = w_deb_inc;
            if (w_deb_inc >= DEB_TGT) begin
              w_state_nxt = ST_SCAN;
              w_row_nxt   = w_row_rot;
              w_deb_nxt   = '0;
            end
          end else begin
            w_state_nxt = ST_PRESSED;
            w_deb_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = ST_SCAN;
          w_row_nxt   = ROW_FIRST;
          w_deb_nxt   = '0;
        end
      endcase
    end

    w_held_nxt = (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE);
  end

  assign keyRow    = r_row;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with SCAN_DIV=4, DEBOUNCE_CNT=3 and a behavioural keypad.
module tb_keypad_scan_ctrl;

  logic       clock;
  logic       reset;
  logic [3:0] keyCol;
  logic [3:0] keyRow;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int unsigned n_vec;
  int unsigned n_err;
  int unsigned n_valid;

  logic       press_en;
  logic [1:0] press_row;
  logic [1:0] press_col;
  logic       mk_en;

  logic [3:0] row_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .keyCol    (keyCol),
    .keyRow    (keyRow),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Keypad model: a closed key pulls its column low only while its row is driven.
  always_comb begin
    keyCol = 4'b1111;
    if (mk_en && !keyRow[0])
      keyCol = 4'b1100;
    else if (press_en && !keyRow[press_row])
      keyCol = ~(4'b0001 << press_col);
  end

  always @(negedge clock) if (key_valid) n_valid++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clock);
  endtask

  initial begin
    n_vec = 0; n_err = 0; n_valid = 0;
    press_en = 1'b0; press_row = 2'd0; press_col = 2'd0; mk_en = 1'b0;
    reset = 1'b0;
    step(3);
    check("rst_row",   32'(keyRow),    32'h0E);
    check("rst_code",  32'(key_code),  32'h0);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_held",  32'(key_held),  32'h0);
    reset = 1'b1;                          // cycle 0

    // idle scan: row advances every 4 clocks
    for (int i = 1; i <= 10; i++) begin
      step(4);
      check("idle_row", 32'(keyRow), 32'(row_seq[i % 4]));
    end
    check("idle_novalid", n_valid, 0);

    // clean press of row 2 / col 1 at cycle 40
    press_en = 1'b1; press_row = 2'd2; press_col = 2'd1;
    step(11);
    check("deb_valid0", 32'(key_valid), 32'h0);
    check("deb_held0",  32'(key_held),  32'h0);
    step(1);                               // cycle 52
    check("press_valid", 32'(key_valid), 32'h1);
    check("press_code",  32'(key_code),  32'h9);
    check("press_held",  32'(key_held),  32'h1);
    check("press_row",   32'(keyRow),    32'hB);
    step(1);
    check("pulse_width", 32'(key_valid), 32'h0);
    check("held_after",  32'(key_held),  32'h1);

    // release bounce: two idle ticks then the key reappears
    press_en = 1'b0;
    step(5);                               // cycle 58
    check("rel_held", 32'(key_held), 32'h1);
    step(2);
    press_en = 1'b1;                       // cycle 60
    step(4);                               // cycle 64
    check("rebounce_held", 32'(key_held), 32'h1);
    check("rebounce_nv",   n_valid, 1);
    press_en = 1'b0;
    step(11);                              // cycle 75
    check("rel2_held", 32'(key_held), 32'h1);
    step(1);                               // cycle 76
    check("released",     32'(key_held), 32'h0);
    check("rel_rowadv",   32'(keyRow),   32'h7);
    check("rel_code",     32'(key_code), 32'h9);
    check("rel_nv",       n_valid, 1);

    // press bounce: two matching ticks then open
    step(12);                              // cycle 88, row 2 driven
    check("bnc_row", 32'(keyRow), 32'hB);
    press_en = 1'b1;
    step(8);                               // cycle 96
    check("bnc_held",    32'(key_held), 32'h0);
    check("bnc_rowhold", 32'(keyRow),   32'hB);
    press_en = 1'b0;
    step(4);                               // cycle 100
    check("bnc_rowadv", 32'(keyRow), 32'h7);
    check("bnc_nv",     n_valid, 1);
    step(4);                               // cycle 104
    check("bnc_scan", 32'(keyRow), 32'hE);

    // two columns low on row 0 is ignored
    mk_en = 1'b1;
    step(4);                               // cycle 108
    check("mk_row",  32'(keyRow),   32'hD);
    check("mk_code", 32'(key_code), 32'h9);
    check("mk_nv",   n_valid, 1);
    mk_en = 1'b0;

    // press row 1 / col 3, then reset while held
    press_en = 1'b1; press_row = 2'd1; press_col = 2'd3;
    step(12);                              // cycle 120
    check("p2_valid", 32'(key_valid), 32'h1);
    check("p2_code",  32'(key_code),  32'h7);
    check("p2_held",  32'(key_held),  32'h1);
    step(2);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_row",   32'(keyRow),    32'hE);
    check("mid_rst_code",  32'(key_code),  32'h0);
    check("mid_rst_valid", 32'(key_valid), 32'h0);
    check("mid_rst_held",  32'(key_held),  32'h0);
    press_en = 1'b0;
    step(3);
    reset = 1'b1;                          // new cycle 0
    step(3);
    check("post_rst_row0", 32'(keyRow), 32'hE);
    step(1);
    check("post_rst_row1", 32'(keyRow), 32'hD);
    step(36);
    check("post_rst_nv",   n_valid, 2);
    check("post_rst_held", 32'(key_held), 32'h0);
    check("post_rst_code", 32'(key_code), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, 50000, clock cycles per scan tick; legal range 2..2^20.
REQ-002 Parameter DEBOUNCE_CNT, 8, consecutive matching ticks required to accept a press or a release; legal range 1..255.
REQ-003 clock  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 keyCol  input  4  keypad column lines, active-low (0 = key closed on the driven row).
REQ-006 keyRow  output  4  keypad row drive, one-hot active-low.
REQ-007 key_code  output  4  last accepted key, {row_idx[1:0], col_idx[1:0]}.
REQ-008 key_valid  output  1  one-cycle pulse when a new key is accepted.
REQ-009 key_held  output  1  high while the accepted key remains pressed.

Function
REQ-010 keyCol SHALL pass through a 2-flop synchronizer before any use; every "keyCol" below refers to the synchronized value.
REQ-011 A prescaler SHALL count 0..SCAN_DIV-1 and wrap, asserting tick for one cycle when count == SCAN_DIV-1.
REQ-012 row_idx/col_idx SHALL be the index of the single 0 bit in keyRow/keyCol (bit 0 = index 0).
REQ-013 FSM states SHALL be SCAN, DEBOUNCE, PRESSED, RELEASE; all transitions occur only on tick cycles except reset.
REQ-014 SCAN: on tick, if keyCol has exactly one 0 bit, latch keyRow/keyCol pattern, set deb_cnt=1, go DEBOUNCE (row held); otherwise rotate keyRow 1110->1101->1011->0111->1110.
REQ-015 SCAN: keyCol with zero or two-plus 0 bits on a tick SHALL be treated as no key (multi-key ignored).
REQ-016 DEBOUNCE: on tick, if keyCol equals latched pattern, increment deb_cnt; if the incremented value equals DEBOUNCE_CNT go PRESSED.
REQ-017 DEBOUNCE: on tick with keyCol mismatching the latch, return to SCAN and rotate keyRow to next row.
REQ-018 With DEBOUNCE_CNT=1 the SCAN tick that latches the key SHALL go directly to PRESSED.
REQ-019 On entry to PRESSED, key_code SHALL update and key_valid SHALL be 1 for exactly the cycle following the accepting tick.
REQ-020 key_held SHALL be 1 in PRESSED and RELEASE, 0 in SCAN and DEBOUNCE.
REQ-021 PRESSED: keyRow held; on tick with keyCol == 1111 set deb_cnt=1 and go RELEASE (or SCAN if DEBOUNCE_CNT=1); any other pattern stays.
REQ-022 RELEASE: on tick with keyCol == 1111 increment deb_cnt, go SCAN on reaching DEBOUNCE_CNT (keyRow rotates to next row); on any non-1111 tick return to PRESSED without a new key_valid.
REQ-023 key_code SHALL hold its value until the next accepted key; it never changes outside REQ-019.
REQ-024 deb_cnt SHALL be 8 bits and never wrap (saturating compare against DEBOUNCE_CNT).

Reset
REQ-025 Reset assertion SHALL immediately force: state SCAN, keyRow 1110, key_code 0000, key_valid 0, key_held 0, prescaler 0, deb_cnt 0, synchronizer 1111.
REQ-026 Reset mid-press SHALL not produce key_valid on release; first tick after deassertion samples row 0.

Structure
REQ-027 Package keypad_pkg SHALL hold the FSM state enum, ROW_IDLE = 4'b1111, ROW_FIRST = 4'b1110 and default parameter values.
REQ-028 The prescaler SHALL be sub-module scan_tick (parameter SCAN_DIV, ports clock, reset, tick); FSM, synchronizer and code encoder stay in keypad_scan_ctrl.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3)
REQ-029 Idle: keyCol=1111 for 40 cycles -> keyRow steps every 4 cycles 1110,1101,1011,0111,1110; key_valid never 1.
REQ-030 Clean press: close row 2/col 1 (keyCol=1101 when keyRow=1011) -> key_valid one pulse after the 3rd matching tick, key_code=1001, key_held=1.
REQ-031 Bounce: press matches for 2 ticks then 1111 -> no key_valid, FSM to SCAN, keyRow advances to 0111.
REQ-032 Release bounce: during hold, 1111 for 2 ticks then 1101 -> key_held stays 1, no second key_valid; 3 consecutive 1111 ticks -> key_held 0.
REQ-033 Multi-key: keyCol=1100 on row 0 -> ignored, scan continues, key_code unchanged.
REQ-034 Reset asserted in PRESSED -> outputs take REQ-025 values same cycle; after release and deassert, no key_valid.
